pux_si_seq: RTL and testbench
=============================

PUX_SI_SEQ -- requirements
Module: pux_si_seq

Interface
REQ-001 SHALL have parameter OPCW, default 8, opcode width.
REQ-002 SHALL have parameter DATAW, default 16, operand word width.
REQ-003 SHALL have parameter STATUSW, default 2, status width (>=2).
REQ-004 SHALL have parameter OPFIFOW, default 3, opcode FIFO pointer width; depth = 2^OPFIFOW.
REQ-005 SHALL have parameter NWORDS, default 4, words per operand (>=1).
REQ-006 SHALL have parameter WCNTW, default 3, word counter width; 2^WCNTW > NWORDS.
REQ-007 SHALL have port axis_clk  in  1  single clock, rising edge.
REQ-008 SHALL have port axis_rstn  in  1  reset, synchronous, active-low.
REQ-009 SHALL have ports axis_opcode_data/valid/ready  in/in/out  OPCW/1/1  opcode AXI-Stream slave.
REQ-010 SHALL have ports axis_abuff_data/valid/ready  in/in/out  DATAW/1/1  operand A slave.
REQ-011 SHALL have ports axis_bbuff_data/valid/ready  in/in/out  DATAW/1/1  operand B slave.
REQ-012 SHALL have ports axis_mbuff_data/valid/ready  in/in/out  DATAW/1/1  modulus M slave.
REQ-013 SHALL have ports axis_status_data/valid/ready  out/out/in  STATUSW/1/1  status master.
REQ-014 SHALL have port stream_request  out  1  one-cycle operand fetch request.
REQ-015 SHALL have port opc_level  out  OPFIFOW+1  opcode FIFO occupancy.
REQ-016 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-017 Opcode FIFO SHALL use OPFIFOW+1-bit wrapping read/write pointers; empty = pointers equal; full = MSBs differ, lower bits equal.
REQ-018 axis_opcode_ready SHALL equal !full; a pop in the same cycle does not make a full FIFO accept.
REQ-019 Simultaneous push and pop SHALL leave opc_level unchanged; opc_level = wptr - rptr modulo 2^(OPFIFOW+1).
REQ-020 FSM states SHALL be IDLE, LOAD, STATUS.
REQ-021 In IDLE with FIFO non-empty, the block SHALL pop the head opcode into a current-opcode register in that cycle.
REQ-022 Popped opcode 0x02 (MUL) or 0x11 (MLOAD) SHALL move to LOAD; any other opcode SHALL move directly to STATUS, consuming no operands.
REQ-023 stream_request SHALL be high exactly in the first LOAD cycle after each IDLE->LOAD transition, low otherwise.
REQ-024 In LOAD, MUL SHALL require A, B and M channels; MLOAD SHALL require M only.
REQ-025 Each operand ready SHALL be high only in LOAD, for a required channel, while its word counter < NWORDS; unrequired channels keep ready low.
REQ-026 Each channel SHALL have an independent WCNTW-bit counter, incremented on valid&&ready, cleared on entry to LOAD.
REQ-027 LOAD->STATUS SHALL occur the cycle after every required counter reaches NWORDS; channels may complete in any order or cycle.
REQ-028 Status code SHALL be 2'b10 for MUL, 2'b01 for MLOAD, 2'b00 for illegal opcode, zero-extended to STATUSW.
REQ-029 axis_status_valid SHALL be high throughout STATUS; data SHALL be stable while valid and ready low.
REQ-030 On status valid&&ready the FSM SHALL return to IDLE; next pop occurs no earlier than the following cycle.
REQ-031 Latency: opcode accepted at cycle N into empty idle block -> popped at N+1 -> stream_request at N+2; illegal opcode -> status valid at N+2.

Reset
REQ-032 While axis_rstn is low at a clock edge: pointers, counters, opcode register cleared; state IDLE.
REQ-033 Reset values: all operand readies 0, axis_status_valid 0, axis_status_data 0, stream_request 0, busy 0, opc_level 0; axis_opcode_ready 1 after first reset edge.
REQ-034 Reset asserted mid-LOAD or mid-STATUS SHALL abort the operation and discard FIFO contents; no status is produced.

Verification
REQ-035 Push 0x11, M supplies 4 words with gaps -> stream_request one pulse, A/B ready never high, status 2'b01.
REQ-036 Push 0x02, A, B, M complete at different cycles -> status 2'b10 one cycle after last of 12 words accepted.
REQ-037 Push 0x05 -> no operand ready, status 2'b00 at N+2, no stream_request.
REQ-038 Push 9 opcodes with status ready low -> 8 accepted, opcode ready low, opc_level 8 minus popped; drain status -> all retire in order.
REQ-039 Hold status ready low 10 cycles -> valid/data stable; same-cycle push+pop keeps opc_level constant.
REQ-040 Deassert axis_rstn mid-LOAD -> next edge readies 0, busy 0, opc_level 0, no status emitted.

Source files
------------

// File: rtl/pux_si_seq.sv
// Opcode sequencer: queues opcodes, fetches the operand words each one needs
// over AXI-Stream slaves, then reports a per-opcode status code.
module pux_si_seq #(
  parameter int OPCW    = 8,
  parameter int DATAW   = 16,
  parameter int STATUSW = 2,
  parameter int OPFIFOW = 3,
  parameter int NWORDS  = 4,
  parameter int WCNTW   = 3
) (
  input  logic               axis_clk,
  input  logic               axis_rstn,
  input  logic [OPCW-1:0]    axis_opcode_data,
  input  logic               axis_opcode_valid,
  output logic               axis_opcode_ready,
  input  logic [DATAW-1:0]   axis_abuff_data,
  input  logic               axis_abuff_valid,
  output logic               axis_abuff_ready,
  input  logic [DATAW-1:0]   axis_bbuff_data,
  input  logic               axis_bbuff_valid,
  output logic               axis_bbuff_ready,
  input  logic [DATAW-1:0]   axis_mbuff_data,
  input  logic               axis_mbuff_valid,
  output logic               axis_mbuff_ready,
  output logic [STATUSW-1:0] axis_status_data,
  output logic               axis_status_valid,
  input  logic               axis_status_ready,
  output logic               stream_request,
  output logic [OPFIFOW:0]   opc_level,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshakes: a beat transfers on a rising edge where valid && ready; a
  // master holds valid and data until that edge, readies never wait on valid.

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STATUS = 2'd2} state_t;

  localparam int DEPTH = 1 << OPFIFOW;
  localparam logic [OPCW-1:0]  OP_MUL   = OPCW'(8'h02);
  localparam logic [OPCW-1:0]  OP_MLOAD = OPCW'(8'h11);
  localparam logic [WCNTW-1:0] NW       = WCNTW'(NWORDS);

  state_t state, state_nxt;

  logic [OPCW-1:0]  opc_mem [DEPTH];
  logic [OPFIFOW:0] wptr, rptr;
  logic             full, empty, push, pop;
  logic [OPCW-1:0]  head, cur_op;
  logic             head_is_load;
  logic             need_ab, need_m;
  logic [WCNTW-1:0] cnt_a, cnt_b, cnt_m;
  logic             acc_a, acc_b, acc_m, all_done;
  logic             first_load;
  logic             unused_data;

  assign unused_data = ^{axis_abuff_data, axis_bbuff_data, axis_mbuff_data};

  function automatic logic [STATUSW-1:0] code_of(input logic [OPCW-1:0] op);
    if (op == OP_MUL)        return STATUSW'(2'b10);
    else if (op == OP_MLOAD) return STATUSW'(2'b01);
    else                     return STATUSW'(2'b00);
  endfunction

  // Opcode FIFO with one extra pointer bit to tell full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[OPFIFOW] != rptr[OPFIFOW]) &&
                 (wptr[OPFIFOW-1:0] == rptr[OPFIFOW-1:0]);
  assign axis_opcode_ready = !full;
  assign push      = axis_opcode_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign opc_level = wptr - rptr;
  assign head      = opc_mem[rptr[OPFIFOW-1:0]];
  assign head_is_load = (head == OP_MUL) || (head == OP_MLOAD);

  always_ff @(posedge axis_clk) begin
    if (push) opc_mem[wptr[OPFIFOW-1:0]] <= axis_opcode_data;
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  assign need_ab = (cur_op == OP_MUL);
  assign need_m  = (cur_op == OP_MUL) || (cur_op == OP_MLOAD);

  assign axis_abuff_ready = (state == LOAD) && need_ab && (cnt_a < NW);
  assign axis_bbuff_ready = (state == LOAD) && need_ab && (cnt_b < NW);
  assign axis_mbuff_ready = (state == LOAD) && need_m  && (cnt_m < NW);

  assign acc_a = axis_abuff_valid && axis_abuff_ready;
  assign acc_b = axis_bbuff_valid && axis_bbuff_ready;
  assign acc_m = axis_mbuff_valid && axis_mbuff_ready;

  // Completion looks at the registered counts, so STATUS follows one cycle
  // after the last word lands.
  assign all_done = (!need_ab || (cnt_a == NW && cnt_b == NW)) &&
                    (!need_m  || (cnt_m == NW));

  always_ff @(posedge axis_clk) begin
    if (!axis_rstn) begin
      state      <= IDLE;
      cur_op     <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      cnt_m      <= '0;
      first_load <= 1'b0;
    end else begin
      state      <= state_nxt;
      first_load <= pop && head_is_load;
      if (pop) cur_op <= head;
      if (pop && head_is_load) begin
        cnt_a <= '0;
        cnt_b <= '0;
        cnt_m <= '0;
      end else begin
        if (acc_a) cnt_a <= cnt_a + 1'b1;
        if (acc_b) cnt_b <= cnt_b + 1'b1;
        if (acc_m) cnt_m <= cnt_m + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = head_is_load ? LOAD : STATUS;
      LOAD:    if (all_done) state_nxt = STATUS;
      STATUS:  if (axis_status_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stream_request    = first_load;
  assign axis_status_valid = (state == STATUS);
  assign axis_status_data  = (state == STATUS) ? code_of(cur_op) : '0;
  assign busy              = (state != IDLE);
  assign dbg_state         = state;

endmodule

// File: tb/tb_pux_si_seq.sv
// Directed bench for pux_si_seq: operand fetch, illegal opcodes, FIFO full,
// status back-pressure and mid-operation reset.
module tb_pux_si_seq;

  logic        clk;
  logic        rstn;
  logic [7:0]  opc_data;
  logic        opc_valid, opc_ready;
  logic [15:0] a_data, b_data, m_data;
  logic        a_valid, a_ready, b_valid, b_ready, m_valid, m_ready;
  logic [1:0]  st_data;
  logic        st_valid, st_ready;
  logic        stream_request;
  logic [3:0]  opc_level;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int sr_cnt = 0, ab_cnt = 0, sv_cnt = 0;
  logic [1:0] exp_q[$];

  pux_si_seq dut (
    .axis_clk(clk), .axis_rstn(rstn),
    .axis_opcode_data(opc_data), .axis_opcode_valid(opc_valid), .axis_opcode_ready(opc_ready),
    .axis_abuff_data(a_data), .axis_abuff_valid(a_valid), .axis_abuff_ready(a_ready),
    .axis_bbuff_data(b_data), .axis_bbuff_valid(b_valid), .axis_bbuff_ready(b_ready),
    .axis_mbuff_data(m_data), .axis_mbuff_valid(m_valid), .axis_mbuff_ready(m_ready),
    .axis_status_data(st_data), .axis_status_valid(st_valid), .axis_status_ready(st_ready),
    .stream_request(stream_request), .opc_level(opc_level), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "global timeout");
  end

  always @(negedge clk) begin
    if (stream_request) sr_cnt <= sr_cnt + 1;
    if (a_ready || b_ready) ab_cnt <= ab_cnt + 1;
    if (st_valid) sv_cnt <= sv_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drives one opcode beat at a negedge, retracts it a cycle later.
  task automatic push_op(input logic [7:0] op);
    opc_data  = op;
    opc_valid = 1'b1;
    step();
    opc_valid = 1'b0;
  endtask

  initial begin : main
    int sr0, ab0, sv0;
    logic [7:0] ops [9];
    ops = '{8'h02, 8'h11, 8'h00, 8'h11, 8'h02, 8'hff, 8'h11, 8'h07, 8'h02};

    rstn = 1'b0; opc_data = '0; opc_valid = 1'b0;
    a_data = '0; b_data = '0; m_data = '0;
    a_valid = 1'b0; b_valid = 1'b0; m_valid = 1'b0; st_ready = 1'b0;
    repeat (2) step();
    chk("rst_readies", {29'd0, a_ready, b_ready, m_ready}, 32'd0);
    chk("rst_st_valid", st_valid, 0);
    chk("rst_st_data", st_data, 0);
    chk("rst_stream_req", stream_request, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", opc_level, 0);
    chk("rst_opc_ready", opc_ready, 1);
    rstn = 1'b1;
    step();

    // Illegal opcode: status 00 two cycles after acceptance, no operands.
    #1; sr0 = sr_cnt; ab0 = ab_cnt;
    chk("ill_opc_ready", opc_ready, 1);
    push_op(8'h05);
    chk("ill_level_n1", opc_level, 1);
    step();
    chk("ill_st_valid_n2", st_valid, 1);
    chk("ill_st_data", st_data, 2'b00);
    chk("ill_no_ready", {29'd0, a_ready, b_ready, m_ready}, 32'd0);
    st_ready = 1'b1;
    step();
    chk("ill_retired", st_valid, 0);
    chk("ill_idle", busy, 0);
    st_ready = 1'b0;
    #1;
    chk("ill_no_stream", sr_cnt - sr0, 0);
    chk("ill_no_ab", ab_cnt - ab0, 0);

    // MLOAD with gapped M words.
    sr0 = sr_cnt; ab0 = ab_cnt;
    push_op(8'h11);
    step();
    chk("mload_stream_req", stream_request, 1);
    chk("mload_m_ready", m_ready, 1);
    for (int i = 0; i < 4; i++) begin
      m_valid = 1'b1; m_data = 16'h100 + 16'(i);
      step();
      m_valid = 1'b0;
      step();
    end
    chk("mload_st_valid", st_valid, 1);
    chk("mload_st_data", st_data, 2'b01);
    #1;
    chk("mload_one_pulse", sr_cnt - sr0, 1);
    chk("mload_ab_never", ab_cnt - ab0, 0);
    st_ready = 1'b1;
    step();
    st_ready = 1'b0;
    chk("mload_retired", st_valid, 0);

    // MUL: A back-to-back, B every other cycle, M late; last word in cycle 9.
    sr0 = sr_cnt;
    push_op(8'h02);
    step();
    chk("mul_stream_req", stream_request, 1);
    for (int cy = 0; cy < 12; cy++) begin
      a_valid = (cy < 4);
      b_valid = (cy < 8) && (cy % 2 == 1);
      m_valid = (cy >= 6) && (cy < 10);
      if (cy == 4)  chk("mul_a_full_ready", a_ready, 0);
      if (cy == 11) begin
        chk("mul_st_valid", st_valid, 1);
        chk("mul_st_data", st_data, 2'b10);
      end
      if (cy < 11) step();
    end
    a_valid = 1'b0; b_valid = 1'b0; m_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_st_valid", st_valid, 1);
      chk("hold_st_data", st_data, 2'b10);
    end
    #1;
    chk("mul_one_pulse", sr_cnt - sr0, 1);
    st_ready = 1'b1;
    step();
    st_ready = 1'b0;
    chk("mul_retired", busy, 0);

    // FIFO full while status is held off, then drain in order.
    push_op(8'h05);
    step();
    chk("full_stuck", st_valid, 1);
    exp_q.push_back(2'b00);
    for (int i = 0; i < 9; i++) begin
      opc_data = ops[i]; opc_valid = 1'b1;
      chk("full_opc_ready", opc_ready, (i < 8) ? 1 : 0);
      step();
    end
    opc_valid = 1'b0;
    chk("full_level", opc_level, 8);
    chk("full_ready_low", opc_ready, 0);
    foreach (exp_q[i]) ; // keep queue as-is
    exp_q.push_back(2'b10); exp_q.push_back(2'b01); exp_q.push_back(2'b00);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b00);
    exp_q.push_back(2'b01); exp_q.push_back(2'b00);
    a_valid = 1'b1; b_valid = 1'b1; m_valid = 1'b1; st_ready = 1'b1;
    for (int c = 0; c < 600 && exp_q.size() > 0; c++) begin
      if (st_valid) chk("drain_order", st_data, exp_q.pop_front());
      step();
    end
    chk("drain_left", exp_q.size(), 0);
    a_valid = 1'b0; b_valid = 1'b0; m_valid = 1'b0; st_ready = 1'b0;
    step();
    chk("drain_level", opc_level, 0);
    chk("drain_idle", busy, 0);

    // Same-cycle push and pop keeps the level.
    push_op(8'h05);
    chk("pp_level_before", opc_level, 1);
    opc_data = 8'h06; opc_valid = 1'b1;
    step();
    opc_valid = 1'b0;
    chk("pp_level_same", opc_level, 1);
    st_ready = 1'b1;
    repeat (4) step();
    st_ready = 1'b0;
    chk("pp_drained", opc_level, 0);

    // Reset in the middle of a MUL load with another opcode queued.
    push_op(8'h02);
    push_op(8'h05);
    chk("rl_in_load", a_ready, 1);
    chk("rl_level", opc_level, 1);
    a_valid = 1'b1;
    step(); step();
    a_valid = 1'b0;
    rstn = 1'b0; st_ready = 1'b1;
    step();
    chk("rl_readies", {29'd0, a_ready, b_ready, m_ready}, 32'd0);
    chk("rl_busy", busy, 0);
    chk("rl_level0", opc_level, 0);
    chk("rl_st_valid", st_valid, 0);
    rstn = 1'b1;
    #1; sv0 = sv_cnt;
    repeat (5) step();
    #1;
    chk("rl_no_status", sv_cnt - sv0, 0);
    chk("rl_opc_ready", opc_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
